// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one asynchronous SRAM port between the display reader (DISP),
// the capture writer (CAP) and the colour-transform engine (XFM). SRAM pins are
// registered from the winner of the previous cycle; read data returns two cycles
// after the grant.
module sram_port_arbiter #(
  parameter int unsigned AW       = 20,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  input  logic          cap_req,
  input  logic [AW-1:0] cap_addr,
  input  logic [DW-1:0] cap_wdata,
  output logic          cap_gnt,
  input  logic          xfm_req,
  input  logic          xfm_we,
  input  logic          xfm_lock,
  input  logic [AW-1:0] xfm_addr,
  input  logic [DW-1:0] xfm_wdata,
  output logic          xfm_gnt,
  output logic          xfm_rvalid,
  output logic [DW-1:0] rdata,
  output logic          oSRAM_OE_N,
  output logic          oSRAM_WE_N,
  output logic [AW-1:0] oSRAM_ADDR,
  inout  wire  [DW-1:0] ioSRAM_DATA
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MaxLock = CW'(MAX_LOCK);

  // Arbitration state
  logic          xfm_gnt_q, xfm_gnt_d;
  logic          xfm_lock_q, xfm_lock_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          rr_xfm_q, rr_xfm_d;  // 0: CAP preferred, 1: XFM preferred
  logic          lock_active;

  // Pin and read-return pipeline
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          disp_rd_q, disp_rd_d;
  logic          xfm_rd_q, xfm_rd_d;
  logic          disp_rvalid_q, disp_rvalid_d;
  logic          xfm_rvalid_q, xfm_rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Priority: honoured lock, then DISP, then CAP/XFM round-robin; no grants in reset
  always_comb begin
    disp_gnt    = 1'b0;
    cap_gnt     = 1'b0;
    xfm_gnt     = 1'b0;
    lock_active = xfm_gnt_q & xfm_lock_q & xfm_req & (lock_cnt_q < MaxLock);
    if (rst_n) begin
      if (lock_active) begin
        xfm_gnt = 1'b1;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end else if (cap_req && (!xfm_req || !rr_xfm_q)) begin
        cap_gnt = 1'b1;
      end else if (xfm_req) begin
        xfm_gnt = 1'b1;
      end
    end
  end

  // Lock counter, round-robin pointer and last-cycle XFM history
  always_comb begin
    xfm_gnt_d  = xfm_gnt;
    xfm_lock_d = xfm_lock;
    lock_cnt_d = (xfm_gnt && lock_active) ? lock_cnt_q + CW'(1) : '0;
    rr_xfm_d   = rr_xfm_q;
    if (cap_gnt) begin
      rr_xfm_d = 1'b1;
    end else if (xfm_gnt) begin
      rr_xfm_d = 1'b0;
    end
  end

  // Next pin state from this cycle's winner; address holds when idle
  always_comb begin
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    disp_rd_d = 1'b0;
    xfm_rd_d  = 1'b0;
    if (disp_gnt) begin
      oe_n_d    = 1'b0;
      addr_d    = disp_addr;
      disp_rd_d = 1'b1;
    end else if (cap_gnt) begin
      we_n_d  = 1'b0;
      addr_d  = cap_addr;
      wdata_d = cap_wdata;
    end else if (xfm_gnt) begin
      addr_d = xfm_addr;
      if (xfm_we) begin
        we_n_d  = 1'b0;
        wdata_d = xfm_wdata;
      end else begin
        oe_n_d   = 1'b0;
        xfm_rd_d = 1'b1;
      end
    end
  end

  // Capture the bus at the end of a read access cycle; rdata holds otherwise
  always_comb begin
    disp_rvalid_d = disp_rd_q;
    xfm_rvalid_d  = xfm_rd_q;
    rdata_d       = (disp_rd_q || xfm_rd_q) ? ioSRAM_DATA : rdata_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfm_gnt_q     <= 1'b0;
      xfm_lock_q    <= 1'b0;
      lock_cnt_q    <= '0;
      rr_xfm_q      <= 1'b0;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      disp_rd_q     <= 1'b0;
      xfm_rd_q      <= 1'b0;
      disp_rvalid_q <= 1'b0;
      xfm_rvalid_q  <= 1'b0;
      rdata_q       <= '0;
    end else begin
      xfm_gnt_q     <= xfm_gnt_d;
      xfm_lock_q    <= xfm_lock_d;
      lock_cnt_q    <= lock_cnt_d;
      rr_xfm_q      <= rr_xfm_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      disp_rd_q     <= disp_rd_d;
      xfm_rd_q      <= xfm_rd_d;
      disp_rvalid_q <= disp_rvalid_d;
      xfm_rvalid_q  <= xfm_rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  // Bus is driven only during a write access cycle, so it never overlaps OE_N=0
  assign ioSRAM_DATA = we_n_q ? {DW{1'bz}} : wdata_q;
  assign oSRAM_OE_N  = oe_n_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_ADDR  = addr_q;
  assign disp_rvalid = disp_rvalid_q;
  assign xfm_rvalid  = xfm_rvalid_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small asynchronous SRAM read model.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        disp_req, cap_req, xfm_req, xfm_we, xfm_lock;
  logic [19:0] disp_addr, cap_addr, xfm_addr;
  logic [15:0] cap_wdata, xfm_wdata;
  logic        disp_gnt, cap_gnt, xfm_gnt;
  logic        disp_rvalid, xfm_rvalid;
  logic [15:0] rdata;
  logic        sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;
  wire  [15:0] sram_data;

  logic [15:0] mem [0:255];
  int          ntests;
  int          nfail;

  sram_port_arbiter #(.AW(20), .DW(16), .MAX_LOCK(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .cap_req     (cap_req),
    .cap_addr    (cap_addr),
    .cap_wdata   (cap_wdata),
    .cap_gnt     (cap_gnt),
    .xfm_req     (xfm_req),
    .xfm_we      (xfm_we),
    .xfm_lock    (xfm_lock),
    .xfm_addr    (xfm_addr),
    .xfm_wdata   (xfm_wdata),
    .xfm_gnt     (xfm_gnt),
    .xfm_rvalid  (xfm_rvalid),
    .rdata       (rdata),
    .oSRAM_OE_N  (sram_oe_n),
    .oSRAM_WE_N  (sram_we_n),
    .oSRAM_ADDR  (sram_addr),
    .ioSRAM_DATA (sram_data)
  );

  // SRAM drives the bus while output enable is asserted
  assign sram_data = (!sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge
  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'hBEEF;
    mem[8'h40] = 16'h4444;
    mem[8'h60] = 16'h6060;
    rst_n = 1'b0;
    disp_req = 1'b0; cap_req = 1'b0; xfm_req = 1'b0; xfm_we = 1'b0; xfm_lock = 1'b0;
    disp_addr = '0; cap_addr = '0; xfm_addr = '0; cap_wdata = '0; xfm_wdata = '0;

    // Reset: idle pins, no grants, no rvalid
    for (int i = 0; i < 10; i++) begin
      nx();
      chk("rst_oe_n", sram_oe_n, 1);
      chk("rst_we_n", sram_we_n, 1);
      chk("rst_addr", sram_addr, 0);
      chk("rst_gnt", {disp_gnt, cap_gnt, xfm_gnt}, 0);
      chk("rst_rvalid", {disp_rvalid, xfm_rvalid}, 0);
      chk("rst_rdata", rdata, 0);
    end
    disp_req = 1'b1;
    #1 chk("rst_gnt_masked", disp_gnt, 0);
    nx();
    rst_n = 1'b1;
    disp_req = 1'b0;
    nx();

    // DISP read of 0x00010
    disp_req = 1'b1; disp_addr = 20'h00010;
    #1;
    chk("disp_gnt", {disp_gnt, cap_gnt, xfm_gnt}, 3'b100);
    nx();
    disp_req = 1'b0;
    chk("disp_acc_oe_n", sram_oe_n, 0);
    chk("disp_acc_we_n", sram_we_n, 1);
    chk("disp_acc_addr", sram_addr, 20'h00010);
    chk("disp_acc_bus", sram_data, 16'hBEEF);
    chk("disp_rvalid_n1", disp_rvalid, 0);
    nx();
    chk("disp_rvalid_n2", disp_rvalid, 1);
    chk("disp_rdata", rdata, 16'hBEEF);
    chk("disp_xfm_rvalid", xfm_rvalid, 0);
    chk("disp_idle_oe_n", sram_oe_n, 1);
    nx();
    chk("disp_rvalid_n3", disp_rvalid, 0);
    chk("disp_rdata_hold", rdata, 16'hBEEF);

    // CAP and XFM writes contend: strict alternation starting with CAP
    cap_req = 1'b1; cap_addr = 20'h00020; cap_wdata = 16'h1111;
    xfm_req = 1'b1; xfm_we = 1'b1; xfm_addr = 20'h00030; xfm_wdata = 16'h2222;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        chk("rr_gnt_cap", {disp_gnt, cap_gnt, xfm_gnt}, 3'b010);
        nx();
        chk("rr_cap_addr", sram_addr, 20'h00020);
        chk("rr_cap_bus", sram_data, 16'h1111);
      end else begin
        chk("rr_gnt_xfm", {disp_gnt, cap_gnt, xfm_gnt}, 3'b001);
        nx();
        chk("rr_xfm_addr", sram_addr, 20'h00030);
        chk("rr_xfm_bus", sram_data, 16'h2222);
      end
      chk("rr_we_n", sram_we_n, 0);
      chk("rr_oe_n", sram_oe_n, 1);
    end
    cap_req = 1'b0; xfm_req = 1'b0;
    nx();
    chk("idle_pins", {sram_oe_n, sram_we_n}, 2'b11);
    chk("idle_addr_hold", sram_addr, 20'h00030);

    // XFM locked read burst; DISP arrives mid-burst and wins after 4 locked grants
    xfm_req = 1'b1; xfm_we = 1'b0; xfm_lock = 1'b1; xfm_addr = 20'h00040;
    #1 chk("lock_first_gnt", {disp_gnt, cap_gnt, xfm_gnt}, 3'b001);
    for (int k = 1; k <= 4; k++) begin
      nx();
      if (k == 1) begin
        disp_req = 1'b1; disp_addr = 20'h00050;
      end
      #1;
      chk("lock_xfm_gnt", {disp_gnt, cap_gnt, xfm_gnt}, 3'b001);
      if (k >= 2) begin
        chk("lock_rvalid", xfm_rvalid, 1);
        chk("lock_rdata", rdata, 16'h4444);
      end
    end
    nx();
    chk("lock_release_disp", {disp_gnt, cap_gnt, xfm_gnt}, 3'b100);
    chk("lock_release_rvalid", xfm_rvalid, 1);
    disp_req = 1'b0;
    nx();
    chk("lock_after_xfm", {disp_gnt, cap_gnt, xfm_gnt}, 3'b001);
    xfm_req = 1'b0; xfm_lock = 1'b0;
    nx(); nx(); nx();

    // XFM read immediately followed by CAP write
    xfm_req = 1'b1; xfm_we = 1'b0; xfm_addr = 20'h00060;
    #1 chk("rw_xfm_gnt", {disp_gnt, cap_gnt, xfm_gnt}, 3'b001);
    nx();
    xfm_req = 1'b0;
    cap_req = 1'b1; cap_addr = 20'h00070; cap_wdata = 16'hCAFE;
    #1;
    chk("rw_cap_gnt", {disp_gnt, cap_gnt, xfm_gnt}, 3'b010);
    chk("rw_rd_pins", {sram_oe_n, sram_we_n}, 2'b01);
    chk("rw_rd_addr", sram_addr, 20'h00060);
    chk("rw_rd_bus", sram_data, 16'h6060);
    nx();
    cap_req = 1'b0;
    chk("rw_wr_pins", {sram_oe_n, sram_we_n}, 2'b10);
    chk("rw_wr_addr", sram_addr, 20'h00070);
    chk("rw_wr_bus", sram_data, 16'hCAFE);
    chk("rw_xfm_rvalid", xfm_rvalid, 1);
    chk("rw_rdata", rdata, 16'h6060);
    nx();

    // Reset in the middle of a DISP read burst, with rr pointing at XFM beforehand
    cap_req = 1'b1; cap_addr = 20'h00020; cap_wdata = 16'h1111;
    #1 chk("mid_pre_cap", cap_gnt, 1);
    nx();
    cap_req = 1'b0;
    disp_req = 1'b1; disp_addr = 20'h00010;
    #1 chk("mid_disp_a", disp_gnt, 1);
    nx();
    chk("mid_disp_b", disp_gnt, 1);
    chk("mid_disp_b_oe", sram_oe_n, 0);
    nx();
    chk("mid_disp_c", disp_gnt, 1);
    chk("mid_disp_c_rvalid", disp_rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pins", {sram_oe_n, sram_we_n}, 2'b11);
    chk("mid_rst_addr", sram_addr, 0);
    chk("mid_rst_gnt", disp_gnt, 0);
    chk("mid_rst_rvalid", disp_rvalid, 0);
    nx();
    rst_n = 1'b1;
    disp_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nx();
      chk("post_rst_rvalid", disp_rvalid, 0);
      chk("post_rst_oe_n", sram_oe_n, 1);
    end
    cap_req = 1'b1; xfm_req = 1'b1; xfm_we = 1'b0; xfm_addr = 20'h00040;
    #1 chk("post_rst_rr_cap", {disp_gnt, cap_gnt, xfm_gnt}, 3'b010);
    nx();
    chk("post_rst_rr_xfm", {disp_gnt, cap_gnt, xfm_gnt}, 3'b001);
    cap_req = 1'b0; xfm_req = 1'b0;
    nx();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single external 16-bit SRAM port between three masters: VGA display reader (DISP, read-only), camera/loader writer (CAP, write-only) and the colour-transform engine (XFM, read/write).
- Registers all SRAM pin outputs and returns read data with a fixed latency.
- Lets XFM lock the port for short bursts, such as its two-word pixel fetch, without starving the display.

Parameters:
- AW, 20, SRAM address width.
- DW, 16, SRAM data width.
- MAX_LOCK, 4, maximum consecutive XFM grants honoured under lock before a forced release.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- disp_req  input  1  DISP read request
- disp_addr  input  AW  DISP address
- disp_gnt  output  1  DISP granted this cycle (combinational)
- disp_rvalid  output  1  DISP read data valid
- cap_req  input  1  CAP write request
- cap_addr  input  AW  CAP address
- cap_wdata  input  DW  CAP write data
- cap_gnt  output  1  CAP granted this cycle (combinational)
- xfm_req  input  1  XFM request
- xfm_we  input  1  XFM write (1) / read (0)
- xfm_lock  input  1  XFM requests to keep the port on the next cycle
- xfm_addr  input  AW  XFM address
- xfm_wdata  input  DW  XFM write data
- xfm_gnt  output  1  XFM granted this cycle (combinational)
- xfm_rvalid  output  1  XFM read data valid
- rdata  output  DW  registered read data, shared by DISP and XFM
- oSRAM_OE_N  output  1  SRAM output enable, active low, registered
- oSRAM_WE_N  output  1  SRAM write enable, active low, registered
- oSRAM_ADDR  output  AW  SRAM address, registered
- ioSRAM_DATA  inout  DW  SRAM data bus

Behaviour:
- Reset (asynchronous, rst_n low):
  - OE_N=1, WE_N=1, ADDR=0, data bus high-Z, rdata=0.
  - All rvalid=0, lock counter=0, rr pointer=CAP.
  - Gnt outputs are 0 while rst_n is low.
- Arbitration, cycle N:
  - At most one gnt is high per cycle.
  - A gnt is high only when the matching req is high.
- Priority, cycle N:
  - If lock_active (XFM granted in N-1, xfm_lock was high in N-1, xfm_req is high in N, and lock count < MAX_LOCK): XFM wins.
  - Otherwise DISP wins if disp_req is high.
  - Otherwise CAP and XFM share round-robin. The rr pointer toggles to the non-granted one after each CAP/XFM grant.
- Lock counter:
  - Increments on each XFM grant made under lock_active.
  - Clears on any non-locked grant or when no request is granted.
  - When the counter reaches MAX_LOCK, the next cycle is arbitrated without the lock. XFM loses to a pending DISP or a round-robin-pending CAP.
- Access, cycle N+1 (SRAM pins registered from the cycle-N winner):
  - Read: OE_N=0, WE_N=1, bus high-Z.
  - Write: OE_N=1, WE_N=0, bus driven with the winner's wdata for the whole cycle.
  - No grant: OE_N=1, WE_N=1, ADDR holds its previous value, bus high-Z.
- Read return:
  - ioSRAM_DATA is sampled into rdata at the end of cycle N+1.
  - disp_rvalid or xfm_rvalid is high for exactly one cycle, N+2.
  - Read latency from gnt = 2 cycles; reads are fully pipelined, one per cycle.
  - rdata holds its value when no rvalid is asserted.
- Back-to-back read→write:
  - The bus is driven only in the write's access cycle, so no extra turnaround cycle is inserted.
  - A write never drives in the same cycle that OE_N=0.
- Requesters:
  - Must hold addr/wdata/we stable while req is high and gnt is low.
  - Each gnt cycle consumes exactly one access.
- Reset mid-operation: in-flight accesses are dropped, pins return to idle immediately, and no rvalid is issued afterwards.

Test Plan:
- Reset with all reqs=0 → OE_N=WE_N=1, ADDR=0, bus Z, no gnt, no rvalid for 10 cycles.
- DISP read addr 0x00010; SRAM model returns 0xBEEF → disp_gnt at N, OE_N=0 with ADDR=0x00010 at N+1, disp_rvalid=1 and rdata=0xBEEF at N+2.
- CAP and XFM both requesting continuously, DISP idle → grants alternate CAP, XFM, CAP, XFM; write cycles show WE_N=0 with the correct wdata.
- XFM lock held with MAX_LOCK=4, disp_req raised mid-burst → 4 locked XFM grants, then disp_gnt on the next cycle.
- XFM read at N then CAP write at N+1 → N+1: OE_N=0, bus Z; N+2: WE_N=0, bus=cap_wdata; xfm_rvalid at N+2 carries the read value.
- rst_n pulsed low during a 3-read DISP burst → pins idle immediately, no disp_rvalid after reset, arbitration resumes with rr=CAP.
